// File: rtl/watch_pkg.sv
// Constants shared by the wrist-watch modes: mode codes, button command codes
// and the active-low seven-segment digit table.
package watch_pkg;

  localparam logic [3:0] MODE_TIMER = 4'd2;

  localparam logic [3:0] CMD_START = 4'd2;
  localparam logic [3:0] CMD_MIN   = 4'd3;
  localparam logic [3:0] CMD_SEC10 = 4'd4;
  localparam logic [3:0] CMD_SEC1  = 4'd5;
  localparam logic [3:0] CMD_CLR   = 4'd6;

  // Segment patterns {g,f,e,d,c,b,a}, active-low; element n encodes digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_dec.sv
// BCD digit to active-low seven-segment decoder; non-BCD codes blank the digit.
module seg7_dec import watch_pkg::*; (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) seg = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/timer.sv
// Countdown-timer mode: button-edited MM:SS preset, 1 s BCD countdown and a
// timed buzzer on expiry; digits always show the timer value.
module timer import watch_pkg::*; #(
  parameter int         TICK_DIV   = 50_000_000,
  parameter int         ALARM_SEC  = 5,
  parameter logic [3:0] MODE_TIMER = watch_pkg::MODE_TIMER
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] btn,
  input  logic [3:0] flag,
  input  logic [3:0] state,
  output logic [6:0] out0,
  output logic [6:0] out1,
  output logic [6:0] out2,
  output logic [6:0] out3,
  output logic       out_speaker
);

  localparam logic [25:0] TICK_LAST  = 26'(TICK_DIV - 1);
  localparam logic [7:0]  ALARM_LAST = 8'(ALARM_SEC - 1);

  logic [3:0]  min_t_reg, min_u_reg, sec_t_reg, sec_u_reg;
  logic [3:0]  min_t_next, min_u_next, sec_t_next, sec_u_next;
  logic        running_reg, running_next, alarm_reg, alarm_next;
  logic [7:0]  alarm_sec_reg, alarm_sec_next;
  logic [25:0] tick_reg, tick_next;
  logic [7:0]  btn_prev_reg;

  logic       cmd_en, tick_hit, dec_en, expire, is_zero;
  logic [3:0] dec_min_t, dec_min_u, dec_sec_t, dec_sec_u;

  assign cmd_en   = (&btn_prev_reg) && !(&btn) && (state == MODE_TIMER);
  assign tick_hit = (running_reg || alarm_reg) && (tick_reg == TICK_LAST);
  assign dec_en   = running_reg && tick_hit;
  assign is_zero  = {min_t_reg, min_u_reg, sec_t_reg, sec_u_reg} == 16'd0;
  assign expire   = dec_en && ({dec_min_t, dec_min_u, dec_sec_t, dec_sec_u} == 16'd0);

  // One-second BCD decrement with digit-wise borrow (seconds tens borrow 0 -> 5).
  always_comb begin
    dec_sec_u = sec_u_reg - 4'd1;
    dec_sec_t = sec_t_reg;
    dec_min_u = min_u_reg;
    dec_min_t = min_t_reg;
    if (sec_u_reg == 4'd0) begin
      dec_sec_u = 4'd9;
      dec_sec_t = sec_t_reg - 4'd1;
      if (sec_t_reg == 4'd0) begin
        dec_sec_t = 4'd5;
        dec_min_u = min_u_reg - 4'd1;
        if (min_u_reg == 4'd0) begin
          dec_min_u = 4'd9;
          dec_min_t = min_t_reg - 4'd1;
        end
      end
    end
  end

  always_comb begin
    min_t_next     = min_t_reg;
    min_u_next     = min_u_reg;
    sec_t_next     = sec_t_reg;
    sec_u_next     = sec_u_reg;
    running_next   = running_reg;
    alarm_next     = alarm_reg;
    alarm_sec_next = alarm_sec_reg;
    tick_next      = tick_reg;

    if (running_reg || alarm_reg) tick_next = tick_hit ? 26'd0 : tick_reg + 26'd1;

    if (dec_en) begin
      {min_t_next, min_u_next, sec_t_next, sec_u_next} = {dec_min_t, dec_min_u, dec_sec_t, dec_sec_u};
      if (expire) begin
        running_next   = 1'b0;
        alarm_next     = 1'b1;
        alarm_sec_next = 8'd0;
      end
    end

    if (alarm_reg && tick_hit) begin
      alarm_sec_next = alarm_sec_reg + 8'd1;
      if (alarm_sec_reg == ALARM_LAST) alarm_next = 1'b0;
    end

    // Commands are applied last so a clear or pause overrides a same-cycle decrement.
    if (cmd_en) begin
      if (alarm_reg) alarm_next = 1'b0;
      case (flag)
        CMD_START: if (!expire) begin
          if (running_reg) begin
            running_next = 1'b0;
            {min_t_next, min_u_next, sec_t_next, sec_u_next} = {min_t_reg, min_u_reg, sec_t_reg, sec_u_reg};
          end else if (!is_zero) begin
            running_next = 1'b1;
            tick_next    = 26'd0;
          end
        end
        CMD_MIN: if (!running_reg) begin
          if (min_u_reg == 4'd9) begin
            min_u_next = 4'd0;
            min_t_next = (min_t_reg == 4'd9) ? 4'd0 : min_t_reg + 4'd1;
          end else begin
            min_u_next = min_u_reg + 4'd1;
          end
        end
        CMD_SEC10: if (!running_reg) sec_t_next = (sec_t_reg == 4'd5) ? 4'd0 : sec_t_reg + 4'd1;
        CMD_SEC1:  if (!running_reg) sec_u_next = (sec_u_reg == 4'd9) ? 4'd0 : sec_u_reg + 4'd1;
        CMD_CLR: begin
          {min_t_next, min_u_next, sec_t_next, sec_u_next} = 16'd0;
          running_next = 1'b0;
          alarm_next   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_t_reg     <= 4'd0;
      min_u_reg     <= 4'd0;
      sec_t_reg     <= 4'd0;
      sec_u_reg     <= 4'd0;
      running_reg   <= 1'b0;
      alarm_reg     <= 1'b0;
      alarm_sec_reg <= 8'd0;
      tick_reg      <= 26'd0;
      btn_prev_reg  <= 8'hFF;
    end else begin
      min_t_reg     <= min_t_next;
      min_u_reg     <= min_u_next;
      sec_t_reg     <= sec_t_next;
      sec_u_reg     <= sec_u_next;
      running_reg   <= running_next;
      alarm_reg     <= alarm_next;
      alarm_sec_reg <= alarm_sec_next;
      tick_reg      <= tick_next;
      btn_prev_reg  <= btn;
    end
  end

  logic [3:0] digit [4];
  logic [6:0] seg   [4];

  assign digit[0] = sec_u_reg;
  assign digit[1] = sec_t_reg;
  assign digit[2] = min_u_reg;
  assign digit[3] = min_t_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      seg7_dec u_dec (.bcd(digit[gi]), .seg(seg[gi]));
    end
  endgenerate

  assign out0        = seg[0];
  assign out1        = seg[1];
  assign out2        = seg[2];
  assign out3        = seg[3];
  assign out_speaker = alarm_reg;

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for the countdown timer against a minutes/seconds model.
module tb_timer;

  localparam int TB_TICK  = 4;
  localparam int TB_ALARM = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] btn;
  logic [3:0] flag;
  logic [3:0] state;
  logic [6:0] out0, out1, out2, out3;
  logic       out_speaker;

  int vectors = 0;
  int miscompares = 0;
  int m_min = 0;
  int m_sec = 0;

  timer #(.TICK_DIV(TB_TICK), .ALARM_SEC(TB_ALARM), .MODE_TIMER(4'd2)) dut (
    .clk(clk), .rst(rst), .btn(btn), .flag(flag), .state(state),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3), .out_speaker(out_speaker)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [27:0] disp(input int mins, input int secs);
    return {seg(mins / 10), seg(mins % 10), seg(secs / 10), seg(secs % 10)};
  endfunction

  // Model of an accepted command on a stopped timer.
  task automatic model_cmd(input int f);
    case (f)
      3: m_min = (m_min + 1) % 100;
      4: m_sec = (((m_sec / 10) + 1) % 6) * 10 + m_sec % 10;
      5: m_sec = (m_sec / 10) * 10 + ((m_sec % 10) + 1) % 10;
      6: begin m_min = 0; m_sec = 0; end
      default: ;
    endcase
  endtask

  task automatic model_sub(input int secs);
    int total;
    total = m_min * 60 + m_sec - secs;
    m_min = total / 60;
    m_sec = total % 60;
  endtask

  // Called at a negedge; holds one button low for 'hold' clocks, then releases.
  task automatic press(input int idx, input int f, input int hold);
    flag = 4'(f);
    btn = 8'hFF;
    btn[idx] = 1'b0;
    repeat (hold) @(negedge clk);
    btn = 8'hFF;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; btn = 8'hFF; flag = 4'd0; state = 4'd2;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({out3, out2, out1, out0} !== disp(0, 0)) begin
      miscompares++;
      $display("FAIL reset_digits: got %h want %h", {out3, out2, out1, out0}, disp(0, 0));
    end
    vectors++;
    if (out_speaker !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_speaker: got %b want 0", out_speaker);
    end
  endtask

  task automatic test_edits;
    int fl[5] = '{3, 3, 4, 5, 6};
    for (int i = 0; i < 5; i++) begin
      press(fl[i], fl[i], 5);
      model_cmd(fl[i]);
      vectors++;
      if ({out3, out2, out1, out0} !== disp(m_min, m_sec)) begin
        miscompares++;
        $display("FAIL edit_%0d flag=%0d: got %h want %h (%02d:%02d)", i, fl[i],
                 {out3, out2, out1, out0}, disp(m_min, m_sec), m_min, m_sec);
      end
    end
  endtask

  task automatic test_countdown;
    logic [27:0] want;
    logic        want_spk;
    press(5, 5, 5); model_cmd(5);
    press(5, 5, 5); model_cmd(5);
    flag = 4'd2; btn = 8'hFF; btn[1] = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 5) btn = 8'hFF;
      if (c == 4 || c == 5 || c == 8 || c == 9 || c == 16 || c == 17) begin
        want = disp(0, (c < 5) ? 2 : (c < 9) ? 1 : 0);
        want_spk = (c >= 9 && c <= 16);
        vectors++;
        if ({out3, out2, out1, out0} !== want || out_speaker !== want_spk) begin
          miscompares++;
          $display("FAIL countdown_c%0d: got %h spk %b want %h spk %b", c,
                   {out3, out2, out1, out0}, out_speaker, want, want_spk);
        end
      end
    end
    m_sec = 0;
    // A non-command press must silence a sounding alarm.
    press(5, 5, 3); model_cmd(5);
    flag = 4'd2; btn = 8'hFF; btn[1] = 1'b0;
    repeat (3) @(negedge clk);
    btn = 8'hFF;
    repeat (2) @(negedge clk);
    vectors++;
    if (out_speaker !== 1'b1) begin
      miscompares++;
      $display("FAIL alarm_on: got %b want 1", out_speaker);
    end
    press(0, 0, 2);
    m_sec = 0;
    vectors++;
    if (out_speaker !== 1'b0 || {out3, out2, out1, out0} !== disp(0, 0)) begin
      miscompares++;
      $display("FAIL alarm_cancel: got spk %b digits %h want spk 0 digits %h",
               out_speaker, {out3, out2, out1, out0}, disp(0, 0));
    end
  endtask

  task automatic test_borrow;
    press(3, 3, 5); model_cmd(3);
    flag = 4'd2; btn = 8'hFF; btn[1] = 1'b0;
    repeat (5) @(negedge clk);
    btn = 8'hFF;
    model_sub(1);
    vectors++;
    if ({out3, out2, out1, out0} !== disp(m_min, m_sec)) begin
      miscompares++;
      $display("FAIL borrow: got %h want %h (%02d:%02d)", {out3, out2, out1, out0},
               disp(m_min, m_sec), m_min, m_sec);
    end
    @(negedge clk);
    press(6, 6, 2); model_cmd(6);
    repeat (10) @(negedge clk);
    vectors++;
    if ({out3, out2, out1, out0} !== disp(0, 0) || out_speaker !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_running: got %h spk %b want %h spk 0", {out3, out2, out1, out0},
               out_speaker, disp(0, 0));
    end
  endtask

  task automatic test_wrap_mode;
    for (int i = 0; i < 10; i++) begin
      press(5, 5, 2); model_cmd(5);
      vectors++;
      if ({out3, out2, out1, out0} !== disp(m_min, m_sec)) begin
        miscompares++;
        $display("FAIL sec1_wrap_%0d: got %h want %h", i, {out3, out2, out1, out0}, disp(m_min, m_sec));
      end
    end
    for (int i = 0; i < 6; i++) begin press(4, 4, 2); model_cmd(4); end
    vectors++;
    if ({out3, out2, out1, out0} !== disp(m_min, m_sec)) begin
      miscompares++;
      $display("FAIL sec10_wrap: got %h want %h", {out3, out2, out1, out0}, disp(m_min, m_sec));
    end
    for (int i = 0; i < 100; i++) begin
      press(3, 3, 1); model_cmd(3);
      if (i >= 98) begin
        vectors++;
        if ({out3, out2, out1, out0} !== disp(m_min, m_sec)) begin
          miscompares++;
          $display("FAIL min_wrap_%0d: got %h want %h", i, {out3, out2, out1, out0}, disp(m_min, m_sec));
        end
      end
    end
    for (int i = 0; i < 3; i++) begin press(4, 4, 2); model_cmd(4); end
    state = 4'd0;
    press(3, 3, 5);
    press(6, 6, 5);
    vectors++;
    if ({out3, out2, out1, out0} !== disp(m_min, m_sec)) begin
      miscompares++;
      $display("FAIL mode_gate: got %h want %h", {out3, out2, out1, out0}, disp(m_min, m_sec));
    end
    state = 4'd2;
  endtask

  // Pause is driven j negedges after the start drive; decrements landing on the
  // pause edge are dropped.
  task automatic test_pause_at(input int j);
    flag = 4'd2; btn = 8'hFF; btn[1] = 1'b0;
    for (int c = 1; c <= j; c++) begin
      @(negedge clk);
      if (c == 5) btn = 8'hFF;
    end
    btn[2] = 1'b0;
    repeat (5) @(negedge clk);
    btn = 8'hFF;
    model_sub((j - 1) / TB_TICK);
    vectors++;
    if ({out3, out2, out1, out0} !== disp(m_min, m_sec)) begin
      miscompares++;
      $display("FAIL pause_j%0d: got %h want %h (%02d:%02d)", j, {out3, out2, out1, out0},
               disp(m_min, m_sec), m_min, m_sec);
    end
    repeat (20) @(negedge clk);
    vectors++;
    if ({out3, out2, out1, out0} !== disp(m_min, m_sec)) begin
      miscompares++;
      $display("FAIL pause_frozen_j%0d: got %h want %h", j, {out3, out2, out1, out0}, disp(m_min, m_sec));
    end
  endtask

  task automatic test_pause;
    test_pause_at(10);
    test_pause_at(8);
    for (int i = 0; i < 3; i++) test_pause_at(int'($urandom_range(6, 20)));
    press(3, 3, 20); model_cmd(3);
    vectors++;
    if ({out3, out2, out1, out0} !== disp(m_min, m_sec)) begin
      miscompares++;
      $display("FAIL hold_once: got %h want %h", {out3, out2, out1, out0}, disp(m_min, m_sec));
    end
  endtask

  task automatic test_random;
    int codes[7] = '{0, 1, 3, 4, 5, 6, 7};
    int f, st;
    for (int i = 0; i < 40; i++) begin
      f = codes[$urandom_range(0, 6)];
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 15)) : 2;
      state = 4'(st);
      press(int'($urandom_range(0, 7)), f, int'($urandom_range(1, 6)));
      if (st == 2) model_cmd(f);
      vectors++;
      if ({out3, out2, out1, out0} !== disp(m_min, m_sec)) begin
        miscompares++;
        $display("FAIL random_%0d flag=%0d state=%0d: got %h want %h", i, f, st,
                 {out3, out2, out1, out0}, disp(m_min, m_sec));
      end
    end
    state = 4'd2;
  endtask

  task automatic test_reset_mid;
    press(5, 5, 2); model_cmd(5);
    press(4, 4, 2); model_cmd(4);
    flag = 4'd2; btn = 8'hFF; btn[1] = 1'b0;
    repeat (3) @(negedge clk);
    btn = 8'hFF;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_min = 0; m_sec = 0;
    repeat (10) @(negedge clk);
    vectors++;
    if ({out3, out2, out1, out0} !== disp(0, 0) || out_speaker !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got %h spk %b want %h spk 0", {out3, out2, out1, out0},
               out_speaker, disp(0, 0));
    end
  endtask

  initial begin
    rst = 1'b1; btn = 8'hFF; flag = 4'd0; state = 4'd2;
    @(negedge clk);
    test_reset;
    test_edits;
    test_countdown;
    test_borrow;
    test_wrap_mode;
    test_pause;
    test_random;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
